// File: rtl/nios_step_gen_if.sv
// Nios PIO side of the stepper pulse generator: command word in, drive and status out.
interface nios_step_gen_if;
  logic [31:0] cmd_word;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] status;
  logic [31:0] position;

  modport master (
    output cmd_word,
    input  step, dir, busy, done, status, position
  );

  modport slave (
    input  cmd_word,
    output step, dir, busy, done, status, position
  );
endinterface

// File: rtl/nios_step_gen.sv
// Stepper STEP/DIR pulse generator driven by a Nios PIO command word.
// A toggle of cmd_word[31] launches a move of N steps with half-period H ticks,
// preceded by a DIR setup delay. Abort (cmd_word[29]) ends a move on the next clock.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no move; watches for a pending go toggle
// SETUP   | dir driven, waiting DIR_SETUP ticks before first rise
// STEP_HI | step high for H ticks
// STEP_LO | step low for H ticks; counts a finished step at the end
module nios_step_gen #(
  parameter int unsigned PRESCALE  = 50,
  parameter int unsigned DIR_SETUP = 5
) (
  input logic            clk,
  input logic            reset_n,
  nios_step_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STEP_HI, STEP_LO} state_t;

  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [11:0] SETUP_LAST = 12'(DIR_SETUP - 1);

  state_t      state, state_nxt;
  logic [31:0] cmd_q;
  logic        tog_q, tog_nxt;
  logic [15:0] pre_cnt;
  logic        tick;
  logic        accept;
  logic        pending;
  logic [11:0] phase_cnt, phase_nxt;
  logic [11:0] half_q, half_nxt;
  logic [15:0] remaining, rem_nxt;
  logic        step_q, step_nxt;
  logic        dir_q, dir_nxt;
  logic        done_q, done_nxt;
  logic        aborted_q, aborted_nxt;
  logic [31:0] pos_q, pos_nxt;
  logic        unused_rsvd;

  assign unused_rsvd = cmd_q[30];
  assign pending     = (cmd_q[31] != tog_q);
  assign tick        = (pre_cnt == PRE_LAST);

  // Register the PIO word; all decoding works from this copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cmd_q <= '0;
    else          cmd_q <= bus.cmd_word;
  end

  // Free-running tick prescaler, realigned when a move is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          pre_cnt <= '0;
    else if (accept||tick) pre_cnt <= '0;
    else                   pre_cnt <= pre_cnt + 16'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and datapath updates; phase_cnt is a tick down-counter per phase.
  always_comb begin
    state_nxt   = state;
    tog_nxt     = tog_q;
    phase_nxt   = phase_cnt;
    half_nxt    = half_q;
    rem_nxt     = remaining;
    step_nxt    = step_q;
    dir_nxt     = dir_q;
    done_nxt    = 1'b0;
    aborted_nxt = aborted_q;
    pos_nxt     = pos_q;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (pending && !cmd_q[29]) begin
          accept      = 1'b1;
          tog_nxt     = cmd_q[31];
          half_nxt    = (cmd_q[27:16] == 12'd0) ? 12'd1 : cmd_q[27:16];
          dir_nxt     = cmd_q[28];
          aborted_nxt = 1'b0;
          rem_nxt     = cmd_q[15:0];
          phase_nxt   = SETUP_LAST;
          if (cmd_q[15:0] != 16'd0) state_nxt = SETUP;
          else                      done_nxt  = 1'b1;
        end
      end
      default: begin
        if (cmd_q[29]) begin
          state_nxt   = IDLE;
          step_nxt    = 1'b0;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end else if (tick) begin
          if (phase_cnt != 12'd0) begin
            phase_nxt = phase_cnt - 12'd1;
          end else begin
            phase_nxt = half_q - 12'd1;
            case (state)
              STEP_HI: begin
                state_nxt = STEP_LO;
                step_nxt  = 1'b0;
              end
              STEP_LO: begin
                rem_nxt = remaining - 16'd1;
                if (remaining <= 16'd1) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
                end else begin
                  state_nxt = STEP_HI;
                  step_nxt  = 1'b1;
                  pos_nxt   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
                end
              end
              default: begin
                state_nxt = STEP_HI;
                step_nxt  = 1'b1;
                pos_nxt   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
              end
            endcase
          end
        end
      end
    endcase
  end

  // Datapath registers; step clears asynchronously with reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q     <= 1'b0;
      phase_cnt <= '0;
      half_q    <= 12'd1;
      remaining <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pos_q     <= '0;
    end else begin
      tog_q     <= tog_nxt;
      phase_cnt <= phase_nxt;
      half_q    <= half_nxt;
      remaining <= rem_nxt;
      step_q    <= step_nxt;
      dir_q     <= dir_nxt;
      done_q    <= done_nxt;
      aborted_q <= aborted_nxt;
      pos_q     <= pos_nxt;
    end
  end

  assign bus.step     = step_q;
  assign bus.dir      = dir_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.status   = {(state != IDLE), aborted_q, 14'b0, remaining};
  assign bus.position = pos_q;

endmodule

// File: tb/tb_nios_step_gen.sv
// Bench for nios_step_gen: timeline model of each move plus directed checks.
module tb_nios_step_gen;
  localparam int P  = 4;
  localparam int DS = 2;
  localparam int S  = DS * P;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  nios_step_gen_if bus_if();

  nios_step_gen #(.PRESCALE(P), .DIR_SETUP(DS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Model: a move is a timeline measured in clock edges since acceptance.
  int unsigned cyc = 0;
  int unsigned m_acc = 0;
  logic [31:0] m_cmd_q = '0;
  logic [31:0] prev_q;
  logic        m_tog = 1'b0, m_active = 1'b0, m_dir = 1'b0;
  logic        m_aborted = 1'b0, m_done = 1'b0, m_step = 1'b0;
  int          m_n = 0, m_h = 1, m_rem = 0;
  int          e, per, rises;
  logic [31:0] m_base = '0, m_pos = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; m_cmd_q = '0; m_tog = 0; m_active = 0; m_dir = 0;
      m_aborted = 0; m_done = 0; m_step = 0; m_rem = 0; m_pos = '0; m_base = '0;
    end else begin
      prev_q  = m_cmd_q;
      m_cmd_q = bus_if.cmd_word;
      cyc++;
      m_done = 0;
      if (m_active) begin
        e   = int'(cyc - m_acc);
        per = 2 * m_h * P;
        if (prev_q[29]) begin
          m_active = 0; m_step = 0; m_done = 1; m_aborted = 1;
        end else if (e == S + m_n * per) begin
          m_active = 0; m_step = 0; m_done = 1; m_rem = 0;
          m_pos = m_dir ? m_base + 32'(m_n) : m_base - 32'(m_n);
        end else if (e >= S) begin
          rises  = (e - S) / per + 1;
          m_step = ((e - S) % per) < m_h * P;
          m_rem  = m_n - (e - S) / per;
          m_pos  = m_dir ? m_base + 32'(rises) : m_base - 32'(rises);
        end
      end else if (prev_q[31] != m_tog && !prev_q[29]) begin
        m_tog = prev_q[31];
        m_n   = int'(prev_q[15:0]);
        m_h   = (prev_q[27:16] == 12'd0) ? 1 : int'(prev_q[27:16]);
        m_dir = prev_q[28];
        m_aborted = 0;
        m_rem  = m_n;
        m_acc  = cyc;
        m_base = m_pos;
        if (m_n == 0) m_done = 1;
        else          m_active = 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus a running count of step rises.
  int   pulse_cnt = 0;
  logic step_prev = 1'b0;
  always @(negedge clk) begin
    check("step",     32'(bus_if.step), 32'(m_step));
    check("dir",      32'(bus_if.dir),  32'(m_dir));
    check("busy",     32'(bus_if.busy), 32'(m_active));
    check("done",     32'(bus_if.done), 32'(m_done));
    check("status",   bus_if.status, {m_active, m_aborted, 14'b0, 16'(m_rem)});
    check("position", bus_if.position, m_pos);
    if (bus_if.step === 1'b1 && step_prev === 1'b0) pulse_cnt++;
    step_prev = bus_if.step;
  end

  task automatic wait_rises(input int n, input string nm);
    int   seen = 0;
    int   k = 0;
    logic prev = bus_if.step;
    while (seen < n && k < 400) begin
      @(negedge clk);
      k++;
      if (bus_if.step && !prev) seen++;
      prev = bus_if.step;
    end
    if (seen < n) begin
      n_vec++; n_err++;
      $display("FAIL %s: saw %0d rises, required %0d", nm, seen, n);
    end
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus_if.done !== 1'b1 && k < 400);
    if (bus_if.done !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: done not seen, got %b required 1", nm, bus_if.done);
    end
  endtask

  int p0;

  initial begin
    reset_n = 1'b0;
    bus_if.cmd_word = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_status", bus_if.status, 32'h0);
    check("reset_pos",    bus_if.position, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: three steps, H=1, dir=0
    bus_if.cmd_word = 32'h8001_0003;
    @(negedge clk); check("t1_busy_k1", 32'(bus_if.busy), 32'd0);
    @(negedge clk); check("t1_busy_k2", 32'(bus_if.busy), 32'd1);
    repeat (7) @(negedge clk); check("t1_pre_rise", 32'(bus_if.step), 32'd0);
    @(negedge clk);            check("t1_rise",     32'(bus_if.step), 32'd1);
    wait_done("t1_done");
    check("t1_pos",    bus_if.position, 32'hFFFF_FFFD);
    check("t1_status", bus_if.status,   32'h0);
    @(negedge clk); check("t1_done_1clk", 32'(bus_if.done), 32'd0);

    // 2: two steps, H=2, dir=1, go toggled back to 0
    bus_if.cmd_word = 32'h1002_0002;
    repeat (2) @(negedge clk);
    check("t2_dir", 32'(bus_if.dir), 32'd1);
    wait_done("t2_done");
    check("t2_pos", bus_if.position, 32'hFFFF_FFFF);

    // 3: abort during the high phase after the second rise
    bus_if.cmd_word = 32'h9001_0004;
    wait_rises(2, "t3_rises");
    bus_if.cmd_word = 32'hB001_0004;
    repeat (2) @(negedge clk);
    check("t3_step",   32'(bus_if.step), 32'd0);
    check("t3_done",   32'(bus_if.done), 32'd1);
    check("t3_status", bus_if.status, 32'h4000_0003);
    check("t3_pos",    bus_if.position, 32'h0000_0001);
    bus_if.cmd_word = 32'h9001_0004;
    repeat (3) @(negedge clk);

    // 3b: abort during the low phase after the third rise, dir=0
    bus_if.cmd_word = 32'h0001_0004;
    wait_rises(3, "t3b_rises");
    repeat (5) @(negedge clk);
    bus_if.cmd_word = 32'h2001_0004;
    repeat (2) @(negedge clk);
    check("t3b_status", bus_if.status, 32'h4000_0002);
    check("t3b_pos",    bus_if.position, 32'hFFFF_FFFE);
    bus_if.cmd_word = 32'h0001_0004;
    repeat (3) @(negedge clk);

    // 4: N=0 gives a bare done pulse and clears aborted
    p0 = pulse_cnt;
    bus_if.cmd_word = 32'h8005_0000;
    repeat (2) @(negedge clk);
    check("t4_done",   32'(bus_if.done), 32'd1);
    check("t4_status", bus_if.status, 32'h0);
    repeat (4) @(negedge clk);
    check("t4_pulses", 32'(pulse_cnt - p0), 32'd0);

    // 5: go toggled mid-move queues a second move
    p0 = pulse_cnt;
    bus_if.cmd_word = 32'h1001_0002;
    repeat (12) @(negedge clk);
    bus_if.cmd_word = 32'h9001_0003;
    wait_done("t5_done1");
    check("t5_gap_busy", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    check("t5_restart", 32'(bus_if.busy), 32'd1);
    wait_done("t5_done2");
    check("t5_pulses", 32'(pulse_cnt - p0), 32'd5);
    check("t5_pos",    bus_if.position, 32'h0000_0003);

    // 6: H=0 acts as H=1; reset in the middle of a high phase
    bus_if.cmd_word = 32'h0000_0002;
    wait_rises(1, "t6_rise");
    @(negedge clk);
    check("t6_high", 32'(bus_if.step), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_step",   32'(bus_if.step), 32'd0);
    check("t6_rst_busy",   32'(bus_if.busy), 32'd0);
    check("t6_rst_pos",    bus_if.position, 32'h0);
    check("t6_rst_status", bus_if.status, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
